// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready handshake with a two-entry skid buffer,
// flush and a saturating stall counter. All state advances on the falling clock edge.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_branch_target,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_read_data2,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_branch,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_branch_target,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_read_data2,
  output logic [REG_W-1:0]  out_write_reg,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  localparam int ENT_W = 3 * DATA_W + REG_W + 6;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ENT_W-1:0] inEntry;
  logic [ENT_W-1:0] headEntry;
  logic [ENT_W-1:0] skidEntry;
  logic             headVld;
  logic             skidVld;
  logic             accept;
  logic             consume;
  logic             headMemRead;
  logic             headMemWrite;
  logic             headBranch;
  logic             headRegWrite;
  logic             headMemToReg;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_ONE;
  endfunction

  assign inEntry = {in_branch_target, in_zero, in_alu_result, in_read_data2, in_write_reg,
                    in_mem_read, in_mem_write, in_branch, in_reg_write, in_mem_to_reg};

  assign {out_branch_target, out_zero, out_alu_result, out_read_data2, out_write_reg,
          headMemRead, headMemWrite, headBranch, headRegWrite, headMemToReg} = headEntry;

  // Ready is a function of registered state only, so no combinational path from out_ready.
  assign in_ready  = ~skidVld & reset_n;
  assign out_valid = headVld;
  assign accept    = in_valid & in_ready;
  assign consume   = headVld & out_ready;
  assign occupancy = {1'b0, headVld} + {1'b0, skidVld};

  assign out_mem_read   = headMemRead  & headVld;
  assign out_mem_write  = headMemWrite & headVld;
  assign out_branch     = headBranch   & headVld;
  assign out_reg_write  = headRegWrite & headVld;
  assign out_mem_to_reg = headMemToReg & headVld;

  // Head/skid storage; flush only clears valid bits, payload is retained.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      headVld   <= 1'b0;
      skidVld   <= 1'b0;
      headEntry <= '0;
      skidEntry <= '0;
    end else if (flush) begin
      headVld <= 1'b0;
      skidVld <= 1'b0;
    end else if (skidVld) begin
      if (consume) begin
        headEntry <= skidEntry;
        skidVld   <= 1'b0;
      end
    end else if (headVld) begin
      if (accept && consume) begin
        headEntry <= inEntry;
      end else if (accept) begin
        skidEntry <= inEntry;
        skidVld   <= 1'b1;
      end else if (consume) begin
        headVld <= 1'b0;
      end
    end else if (accept) begin
      headEntry <= inEntry;
      headVld   <= 1'b1;
    end
  end

  // Stall counter; clear wins over increment and flush has no effect on it.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (headVld && !out_ready) begin
      stall_cnt <= satInc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed and randomised scoreboard bench for ex_mem_pipe_reg (CNT_W=4 build).
module tb_ex_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  logic              clock;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_branch_target;
  logic              in_zero;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_read_data2;
  logic [REG_W-1:0]  in_write_reg;
  logic              in_mem_read;
  logic              in_mem_write;
  logic              in_branch;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_branch_target;
  logic              out_zero;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_read_data2;
  logic [REG_W-1:0]  out_write_reg;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_branch;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_clr;

  logic [4:0] ctlOut;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [4:0]  ctl;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_branch_target(in_branch_target), .in_zero(in_zero),
    .in_alu_result(in_alu_result), .in_read_data2(in_read_data2),
    .in_write_reg(in_write_reg), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_branch(in_branch),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_branch_target(out_branch_target), .out_zero(out_zero),
    .out_alu_result(out_alu_result), .out_read_data2(out_read_data2),
    .out_write_reg(out_write_reg), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  assign ctlOut = {out_mem_read, out_mem_write, out_branch, out_reg_write, out_mem_to_reg};

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Active edge is the falling edge; sample 1 time unit after it.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] ctl);
    in_valid      = v;
    in_alu_result = alu;
    {in_mem_read, in_mem_write, in_branch, in_reg_write, in_mem_to_reg} = ctl;
  endtask

  task automatic scoreStep();
    item_t obs;
    item_t front;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 64'(out_alu_result), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        front = sb[0];
        obs   = {out_alu_result, out_write_reg, ctlOut};
        chk("sb_head", 64'(obs), 64'(front));
        if (out_ready) void'(sb.pop_front());
      end
    end else begin
      chk("sb_bubble_ctl", 64'(ctlOut), 64'd0);
    end
    if (in_valid && in_ready)
      sb.push_back({in_alu_result, in_write_reg,
                    in_mem_read, in_mem_write, in_branch, in_reg_write, in_mem_to_reg});
  endtask

  initial begin
    reset_n          = 1'b0;
    flush            = 1'b0;
    stall_clr        = 1'b0;
    out_ready        = 1'b0;
    in_branch_target = 32'hCAFE_0001;
    in_zero          = 1'b1;
    in_read_data2    = 32'h5555_AAAA;
    in_write_reg     = 5'd17;
    drive(1'b1, 32'hDEAD_BEEF, 5'b11111);

    // Reset with live inputs
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_alu", 64'(out_alu_result), 64'd0);
    chk("rst_target", 64'(out_branch_target), 64'd0);
    chk("rst_wreg", 64'(out_write_reg), 64'd0);
    chk("rst_ctl", 64'(ctlOut), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);

    reset_n = 1'b1;
    drive(1'b1, 32'h0000_1234, 5'b00000);
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_alu", 64'(out_alu_result), 64'h1234);
    chk("first_wreg", 64'(out_write_reg), 64'd17);
    chk("first_occ", 64'(occupancy), 64'd1);
    drive(1'b0, 32'h0, 5'b0);
    out_ready = 1'b1;
    tick();
    chk("first_drain", 64'(out_valid), 64'd0);
    chk("first_stall", 64'(stall_cnt), 64'd0);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 5'b0);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_alu", 64'(out_alu_result), 64'(i));
    end
    drive(1'b0, 32'h0, 5'b0);
    tick();
    chk("stream_end_valid", 64'(out_valid), 64'd0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Back-pressure: out_ready low for three edges
    drive(1'b1, 32'd11, 5'b0);
    tick();
    chk("bp_a_alu", 64'(out_alu_result), 64'd11);
    drive(1'b1, 32'd12, 5'b0);
    out_ready = 1'b0;
    tick();
    chk("bp_b_occ", 64'(occupancy), 64'd2);
    chk("bp_b_in_ready", 64'(in_ready), 64'd0);
    chk("bp_b_alu", 64'(out_alu_result), 64'd11);
    drive(1'b1, 32'd13, 5'b0);
    tick();
    tick();
    chk("bp_d_occ", 64'(occupancy), 64'd2);
    chk("bp_d_in_ready", 64'(in_ready), 64'd0);
    chk("bp_d_stall", 64'(stall_cnt), 64'd3);
    chk("bp_d_alu", 64'(out_alu_result), 64'd11);
    out_ready = 1'b1;
    tick();
    chk("bp_e_alu", 64'(out_alu_result), 64'd12);
    chk("bp_e_occ", 64'(occupancy), 64'd1);
    chk("bp_e_in_ready", 64'(in_ready), 64'd1);
    chk("bp_e_stall", 64'(stall_cnt), 64'd3);
    tick();
    chk("bp_f_alu", 64'(out_alu_result), 64'd13);
    chk("bp_f_valid", 64'(out_valid), 64'd1);
    drive(1'b0, 32'h0, 5'b0);
    tick();
    chk("bp_g_valid", 64'(out_valid), 64'd0);

    // Saturation and clear
    stall_clr = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'd21, 5'b0);
    tick();
    chk("clr_stall", 64'(stall_cnt), 64'd0);
    stall_clr = 1'b0;
    drive(1'b0, 32'h0, 5'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 64'(stall_cnt), 64'd15);
    chk("sat_alu", 64'(out_alu_result), 64'd21);
    stall_clr = 1'b1;
    tick();
    chk("clr_wins", 64'(stall_cnt), 64'd0);
    stall_clr = 1'b0;
    tick();
    chk("clr_resume", 64'(stall_cnt), 64'd1);

    // Flush with two held entries and an incoming instruction
    drive(1'b1, 32'd22, 5'b01000);
    tick();
    chk("fl_occ2", 64'(occupancy), 64'd2);
    drive(1'b1, 32'd23, 5'b00010);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_reg_write", 64'(out_reg_write), 64'd0);
    chk("fl_mem_write", 64'(out_mem_write), 64'd0);
    chk("fl_payload_kept", 64'(out_alu_result), 64'd21);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'd24, 5'b00010);
    out_ready = 1'b0;
    tick();
    chk("fl_next_alu", 64'(out_alu_result), 64'd24);
    chk("fl_next_reg_write", 64'(out_reg_write), 64'd1);
    drive(1'b0, 32'h0, 5'b0);
    out_ready = 1'b1;
    tick();
    chk("gate_reg_write", 64'(out_reg_write), 64'd0);
    chk("gate_alu_kept", 64'(out_alu_result), 64'd24);

    // Asynchronous reset between edges
    drive(1'b1, 32'd31, 5'b0);
    out_ready = 1'b0;
    tick();
    tick();
    chk("ar_pre_occ", 64'(occupancy), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd0);
    chk("ar_alu", 64'(out_alu_result), 64'd0);
    chk("ar_stall", 64'(stall_cnt), 64'd0);
    #1;
    reset_n = 1'b1;

    // Randomised traffic against a FIFO scoreboard
    for (int c = 0; c < 10000; c++) begin
      in_valid      = 1'($urandom_range(0, 1));
      out_ready     = ($urandom_range(0, 3) != 0);
      in_alu_result = $urandom;
      in_write_reg  = 5'($urandom_range(0, 31));
      {in_mem_read, in_mem_write, in_branch, in_reg_write, in_mem_to_reg} = 5'($urandom_range(0, 31));
      scoreStep();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      scoreStep();
      tick();
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("sb_final_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX/MEM pipeline register with valid/ready flow control, a two-entry skid buffer, synchronous flush and a saturating stall counter. Sits between the execute stage (ALU, branch-target adder) and the memory stage. Lets a stalled memory stage (cache miss) back-pressure execute without losing or duplicating instructions. A flushed or empty stage presents a bubble whose side-effect controls are all 0.

## Interface
- DATA_W, 32, width of branch target, ALU result and store data
- REG_W, 5, width of destination register index
- CNT_W, 16, width of stall counter
- clock  in  1  pipeline clock; all state updates on the falling edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  this block can accept on the next falling edge
- in_branch_target  in  DATA_W  computed branch target
- in_zero  in  1  ALU zero flag
- in_alu_result  in  DATA_W  ALU result / memory address
- in_read_data2  in  DATA_W  store data
- in_write_reg  in  REG_W  destination register
- in_mem_read, in_mem_write, in_branch, in_reg_write, in_mem_to_reg  in  1 each  control bits
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  memory stage has a valid instruction
- out_ready  in  1  memory stage consumes on the next falling edge
- out_branch_target, out_zero, out_alu_result, out_read_data2, out_write_reg  out  as inputs  payload of the head entry
- out_mem_read, out_mem_write, out_branch, out_reg_write, out_mem_to_reg  out  1 each  head-entry controls, gated by out_valid
- occupancy  out  2  number of held entries: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- Storage: head entry H, which drives the outputs, and skid entry S. Each entry has its own valid bit.
- accept = in_valid & in_ready. consume = out_valid & out_ready.
- in_ready = !S.valid & reset_n. It depends only on registered state, never on out_ready or in_valid.
- out_valid = H.valid.
- Transitions per falling edge, flush=0:
  - Empty: accept loads H.
  - H only: accept & consume loads H from input. Accept only loads S. Consume only empties H.
  - H+S: no accept is possible. Consume moves S to H and empties S. Otherwise hold.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated except by flush.
- Flush has top priority. On that edge both valid bits clear, the input is ignored even if accept=1, and any consume is still reported as taken. Payload registers keep their values.
- Control gating: each out_mem_read/mem_write/branch/reg_write/mem_to_reg equals the stored bit & out_valid. Data outputs show the last held payload when empty.
- stall_cnt per edge:
  - stall_clr=1 gives 0. This wins over an increment.
  - Otherwise it increments if out_valid & !out_ready and it is below 2^CNT_W-1.
  - Otherwise it holds.
  - flush does not affect it.
- Reset (reset_n=0, asynchronous): both valid bits 0, all payload 0, stall_cnt=0, occupancy=0, in_ready=0, all out_* = 0. The first accept is possible on the first falling edge after release.

## Timing
- Latency: an instruction accepted at falling edge k drives out_* and out_valid=1 from edge k until it is consumed.
- Throughput: one instruction per cycle when out_ready is held at 1. A continuous stream sees in_ready=1 throughout.
- After out_ready deasserts, the block absorbs exactly one more instruction into S. in_ready falls after that edge.
- After out_ready reasserts, S reaches H on the first consume edge. in_ready rises after that same edge.
- occupancy = H.valid + S.valid, registered.
- Reset asserted mid-transfer: state clears immediately, with no edge required. In-flight instructions are lost by design.

## Test plan
- Reset: reset_n=0 with in_valid=1 and arbitrary inputs → all outputs 0, in_ready=0. After release and one edge with in_alu_result=0x0000_1234 → out_valid=1, out_alu_result=0x1234.
- Streaming: 8 instructions with alu_result 1..8 and out_ready=1 → outputs 1..8 on consecutive edges, in_ready=1 throughout, stall_cnt=0.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 edges during a stream.
  - Required: occupancy reaches 2, in_ready=0, stall_cnt=3, no value lost or repeated.
  - After out_ready returns to 1: sequence continues in order.
- Flush: with occupancy=2 and an incoming instruction with in_reg_write=1, assert flush for 1 edge → occupancy=0, out_valid=0, out_reg_write=0, out_mem_write=0; the next accepted instruction appears next.
- Saturation and clear: CNT_W=4, out_valid=1, out_ready=0 for 20 edges → stall_cnt=15. stall_clr and a stall on the same edge → 0.
- Randomised out_ready and in_valid with a scoreboard over 10,000 cycles → output sequence equals accepted sequence, and control outputs are 0 whenever out_valid=0.
